cam_axi_writer: RTL and testbench

//  Drains the camera pixel FIFO on ACLK and writes frames to DRAM as AXI4 INCR bursts.

---
 rtl/cam_axi_writer_if.sv | 40 ++++
 rtl/cam_axi_writer.sv | 170 +++++++++++++++++
 tb/tb_cam_axi_writer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_axi_writer_if.sv
// Camera FIFO read port plus AXI4 write channels (AW/W/B) of cam_axi_writer.
// master = the writer; slave = the FIFO / memory side.
interface cam_axi_writer_if #(
  parameter int ADDR_W = 32
);
  logic              hasdata;
  logic              fiford;
  logic              fifovalid;
  logic [47:0]       readdata;

  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [3:0]        awcache;
  logic              awvalid;
  logic              awready;

  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  hasdata, fifovalid, readdata, awready, wready, bresp, bvalid,
    output fiford, awaddr, awlen, awsize, awburst, awcache, awvalid,
           wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output hasdata, fifovalid, readdata, awready, wready, bresp, bvalid,
    input  fiford, awaddr, awlen, awsize, awburst, awcache, awvalid,
           wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/cam_axi_writer.sv
// Drains the camera FIFO in whole 8-word bursts and writes them to DRAM as AXI4 INCR bursts.
// Per burst: 8 fetch + 1 read latency + AW + 8 W + B cycles minimum; every VALID holds until its READY.
module cam_axi_writer #(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [CNT_W-1:0]  frame_bursts,
  output logic              busy,
  output logic              frame_done,
  output logic              wr_err,
  cam_axi_writer_if.master  bus
);
  localparam int                PTR_W       = $clog2(BURST_LEN);
  localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0]  PTR_PENULT  = PTR_W'(BURST_LEN - 2);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~(ADDR_W'(BURST_LEN * 8 - 1));

  typedef enum logic [2:0] {IDLE, FETCH, ADDR, DATA, RESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  bursts_left;
  logic [PTR_W-1:0]  rd_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [63:0]       buf_mem [BURST_LEN];
  logic              fiford_r, awvalid_r, wvalid_r, wlast_r, bready_r;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_base;
  logic [CNT_W-1:0]  pend_cnt;

  // A start arriving on the same cycle as the B handshake must still take effect.
  logic              nxt_pend;
  logic [ADDR_W-1:0] nxt_base;
  logic [CNT_W-1:0]  nxt_cnt;

  always_comb begin
    nxt_pend = frame_start | pend_vld;
    nxt_base = frame_start ? frame_base : pend_base;
    nxt_cnt  = frame_start ? frame_bursts : pend_cnt;
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      addr        <= '0;
      bursts_left <= '0;
      rd_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fiford_r    <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      wlast_r     <= 1'b0;
      bready_r    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      wr_err      <= 1'b0;
      pend_vld    <= 1'b0;
      pend_base   <= '0;
      pend_cnt    <= '0;
      for (int i = 0; i < BURST_LEN; i++) buf_mem[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state != IDLE && frame_start) begin
        pend_vld  <= 1'b1;
        pend_base <= frame_base;
        pend_cnt  <= frame_bursts;
      end
      case (state)
        IDLE: begin
          if (frame_start) begin
            pend_vld <= 1'b0;
            if (enable) begin
              wr_err      <= 1'b0;
              addr        <= frame_base & ALIGN_MASK;
              bursts_left <= frame_bursts;
              busy        <= (frame_bursts != '0);
              frame_done  <= (frame_bursts == '0);
            end
          end else if (busy && enable && bus.hasdata) begin
            state    <= FETCH;
            fiford_r <= 1'b1;
            rd_cnt   <= '0;
            wr_ptr   <= '0;
          end
        end
        FETCH: begin
          if (fiford_r) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == PTR_LAST) fiford_r <= 1'b0;
          end
          if (bus.fifovalid) begin
            buf_mem[wr_ptr] <= {8'h00, bus.readdata[47:24], 8'h00, bus.readdata[23:0]};
            wr_ptr          <= wr_ptr + 1'b1;
            if (wr_ptr == PTR_LAST) begin
              state     <= ADDR;
              awvalid_r <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (bus.awready) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            wlast_r   <= 1'b0;
            rd_ptr    <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (bus.wready) begin
            rd_ptr  <= rd_ptr + 1'b1;
            wlast_r <= (rd_ptr == PTR_PENULT);
            if (rd_ptr == PTR_LAST) begin
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state    <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.bvalid) begin
            bready_r <= 1'b0;
            state    <= IDLE;
            if (nxt_pend) begin
              // The running frame is dropped silently in favour of the queued one.
              pend_vld    <= 1'b0;
              wr_err      <= 1'b0;
              addr        <= nxt_base & ALIGN_MASK;
              bursts_left <= nxt_cnt;
              busy        <= (nxt_cnt != '0);
              frame_done  <= (nxt_cnt == '0);
            end else begin
              wr_err      <= wr_err | (bus.bresp != 2'b00);
              addr        <= addr + BURST_BYTES;
              bursts_left <= bursts_left - 1'b1;
              if (bursts_left == CNT_W'(1)) begin
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fiford  = fiford_r;
  assign bus.awaddr  = addr;
  assign bus.awlen   = 8'(BURST_LEN - 1);
  assign bus.awsize  = 3'b011;
  assign bus.awburst = 2'b01;
  assign bus.awcache = 4'b0011;
  assign bus.awvalid = awvalid_r;
  assign bus.wdata   = buf_mem[rd_ptr];
  assign bus.wstrb   = 8'hFF;
  assign bus.wlast   = wlast_r;
  assign bus.wvalid  = wvalid_r;
  assign bus.bready  = bready_r;
endmodule

// File: tb/tb_cam_axi_writer.sv
// Directed bench for cam_axi_writer: FIFO and AXI slave models driven on the falling edge,
// checks against hand-computed addresses, packed pixels and frame status.
module tb_cam_axi_writer;
  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] frame_base = '0;
  logic [15:0] frame_bursts = '0;
  logic        busy, frame_done, wr_err;

  cam_axi_writer_if #(.ADDR_W(32)) bus();

  cam_axi_writer #(.ADDR_W(32), .BURST_LEN(8), .CNT_W(16)) dut (
    .aclk(aclk), .arst(arst), .enable(enable), .frame_start(frame_start),
    .frame_base(frame_base), .frame_bursts(frame_bursts),
    .busy(busy), .frame_done(frame_done), .wr_err(wr_err), .bus(bus)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  logic [47:0] fq[$];
  logic [31:0] aw_log[$];
  logic [63:0] w_dat[$];
  bit          w_last[$];
  logic [7:0]  w_strb[$];
  logic [16:0] aw_attr;
  int fd_cnt = 0, fiford_cnt = 0, stab_err = 0, uf_err = 0;
  int b_owed = 0, b_idx = 0, err_idx = -1;
  bit stall = 1'b0;
  bit aw_hold = 1'b0, w_hold = 1'b0, b_fire = 1'b0;
  logic [31:0] aw_hold_addr;
  logic [63:0] w_hold_dat;
  logic        w_hold_last;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [47:0] mkword(input int i);
    return {8'hC0, 16'(i), 8'h30, 16'(i)};
  endfunction

  function automatic logic [63:0] pack(input logic [47:0] w);
    return {8'h00, w[47:24], 8'h00, w[23:0]};
  endfunction

  // FIFO + AXI slave responder; handshakes are logged on the falling edge before the rising edge that completes them
  initial begin
    bus.hasdata = 1'b0; bus.fifovalid = 1'b0; bus.readdata = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (arst) begin
        bus.fifovalid = 1'b0; bus.bvalid = 1'b0;
        aw_hold = 1'b0; w_hold = 1'b0; b_fire = 1'b0;
        bus.hasdata = (fq.size() >= 8);
        continue;
      end
      if (bus.fiford) begin
        fiford_cnt++;
        if (fq.size() == 0) begin
          uf_err++;
          bus.fifovalid = 1'b0;
        end else begin
          bus.readdata  = fq.pop_front();
          bus.fifovalid = 1'b1;
        end
      end else begin
        bus.fifovalid = 1'b0;
      end
      bus.hasdata = (fq.size() >= 8);
      if (frame_done) fd_cnt++;
      if (aw_hold && (!bus.awvalid || bus.awaddr !== aw_hold_addr)) stab_err++;
      if (w_hold && (!bus.wvalid || bus.wdata !== w_hold_dat || bus.wlast !== w_hold_last)) stab_err++;
      bus.awready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      aw_hold      = bus.awvalid && !bus.awready;
      aw_hold_addr = bus.awaddr;
      w_hold       = bus.wvalid && !bus.wready;
      w_hold_dat   = bus.wdata;
      w_hold_last  = bus.wlast;
      if (bus.awvalid && bus.awready) begin
        aw_log.push_back(bus.awaddr);
        aw_attr = {bus.awlen, bus.awsize, bus.awburst, bus.awcache};
      end
      if (b_fire) begin
        bus.bvalid = 1'b0;
        b_fire = 1'b0;
      end
      if (!bus.bvalid && b_owed > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
        bus.bvalid = 1'b1;
        bus.bresp  = (b_idx == err_idx) ? 2'b10 : 2'b00;
      end
      if (bus.bvalid && bus.bready) begin
        b_fire = 1'b1;
        b_owed--;
        b_idx++;
      end
      if (bus.wvalid && bus.wready) begin
        w_dat.push_back(bus.wdata);
        w_last.push_back(bus.wlast);
        w_strb.push_back(bus.wstrb);
        if (bus.wlast) b_owed++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic start(input logic [31:0] base, input logic [15:0] n);
    @(posedge aclk); #1;
    frame_base = base; frame_bursts = n; frame_start = 1'b1;
    @(posedge aclk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int target);
    int cyc = 0;
    while (fd_cnt < target && cyc < 3000) begin
      @(posedge aclk); #1;
      cyc++;
    end
    chk(tag, 64'(fd_cnt >= target), 64'd1);
  endtask

  task automatic wait_beats(input string tag, input int n);
    int cyc = 0;
    while (w_dat.size() < n && cyc < 3000) begin
      @(posedge aclk); #1;
      cyc++;
    end
    chk(tag, 64'(w_dat.size() >= n), 64'd1);
  endtask

  task automatic clear_logs();
    aw_log.delete(); w_dat.delete(); w_last.delete(); w_strb.delete();
    fd_cnt = 0; b_idx = 0; fiford_cnt = 0; stab_err = 0;
  endtask

  task automatic load(input int first, input int n);
    for (int k = 0; k < n; k++) fq.push_back(mkword(first + k));
  endtask

  function automatic logic [15:0] last_mask();
    logic [15:0] m = '0;
    for (int j = 0; j < w_last.size() && j < 16; j++) m[j] = w_last[j];
    return m;
  endfunction

  task automatic chk_data(input string tag, input int first);
    for (int j = 0; j < w_dat.size(); j++)
      chk($sformatf("%s_wdat%0d", tag, j), w_dat[j], pack(mkword(first + j)));
  endtask

  initial begin
    int fc0;
    // 1: reset state, then two-burst frame
    tick(3);
    chk("rst_ctl", 64'({bus.fiford, bus.awvalid, bus.wvalid, bus.wlast, bus.bready,
                        busy, frame_done, wr_err}), 64'd0);
    chk("rst_awaddr", 64'(bus.awaddr), 64'd0);
    arst = 1'b0; enable = 1'b1;
    tick(2);
    clear_logs();
    load(0, 16);
    start(32'h1000_0000, 16'd2);
    chk("t1_busy_on", 64'(busy), 64'd1);
    wait_fd("t1_done", 1);
    tick(3);
    chk("t1_aw_n", 64'(aw_log.size()), 64'd2);
    chk("t1_aw0", 64'(aw_log[0]), 64'h1000_0000);
    chk("t1_aw1", 64'(aw_log[1]), 64'h1000_0040);
    chk("t1_beats", 64'(w_dat.size()), 64'd16);
    chk("t1_wlast", 64'(last_mask()), 64'h8080);
    chk_data("t1", 0);
    chk("t1_fd", 64'(fd_cnt), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_reads", 64'(fiford_cnt), 64'd16);

    // 2: pixel packing, burst attributes, low base bits dropped
    clear_logs();
    fq.push_back(48'hABCDEF_123456);
    load(100, 7);
    start(32'h0800_0013, 16'd1);
    wait_fd("t2_done", 1);
    tick(2);
    chk("t2_wdat0", w_dat[0], 64'h00ABCDEF_00123456);
    chk("t2_wstrb", 64'(w_strb[0]), 64'hFF);
    chk("t2_attr", 64'(aw_attr), 64'({8'd7, 3'b011, 2'b01, 4'b0011}));
    chk("t2_aw0", 64'(aw_log[0]), 64'h0800_0000);

    // zero-burst frame completes immediately
    clear_logs();
    start(32'h9000_0000, 16'd0);
    chk("t0_fd_pulse", 64'(frame_done), 64'd1);
    chk("t0_busy", 64'(busy), 64'd0);
    tick(5);
    chk("t0_fd_cnt", 64'(fd_cnt), 64'd1);
    chk("t0_aw_n", 64'(aw_log.size()), 64'd0);

    // 3: random stalls on AWREADY / WREADY / BVALID
    clear_logs();
    stall = 1'b1;
    load(200, 16);
    start(32'h3000_0000, 16'd2);
    wait_fd("t3_done", 1);
    tick(3);
    stall = 1'b0;
    chk("t3_aw_n", 64'(aw_log.size()), 64'd2);
    chk("t3_aw1", 64'(aw_log[1]), 64'h3000_0040);
    chk("t3_beats", 64'(w_dat.size()), 64'd16);
    chk("t3_wlast", 64'(last_mask()), 64'h8080);
    chk("t3_stable", 64'(stab_err), 64'd0);
    chk_data("t3", 200);

    // 4: SLVERR on first of three bursts
    clear_logs();
    err_idx = 0;
    load(300, 24);
    start(32'h4000_0000, 16'd3);
    wait_fd("t4_done", 1);
    tick(2);
    err_idx = -1;
    chk("t4_err", 64'(wr_err), 64'd1);
    chk("t4_aw_n", 64'(aw_log.size()), 64'd3);
    chk("t4_aw2", 64'(aw_log[2]), 64'h4000_0080);
    clear_logs();
    load(400, 8);
    start(32'h4100_0000, 16'd1);
    chk("t4_err_clr", 64'(wr_err), 64'd0);
    wait_fd("t4b_done", 1);
    tick(2);
    chk("t4b_err", 64'(wr_err), 64'd0);

    // 5: reset in the middle of the data phase
    clear_logs();
    load(500, 16);
    start(32'h5000_0000, 16'd1);
    wait_beats("t5_reach4", 4);
    arst = 1'b1;
    #1;
    chk("t5_rst_ctl", 64'({bus.fiford, bus.awvalid, bus.wvalid, bus.wlast, bus.bready,
                           busy, frame_done, wr_err}), 64'd0);
    chk("t5_rst_addr", 64'(bus.awaddr), 64'd0);
    tick(2);
    arst = 1'b0;
    fc0 = fiford_cnt;
    tick(20);
    chk("t5_no_fetch", 64'(fiford_cnt), 64'(fc0));
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_fifo_left", 64'(fq.size()), 64'd8);
    clear_logs();
    start(32'h5100_0000, 16'd1);
    wait_fd("t5b_done", 1);
    tick(2);
    chk("t5b_aw0", 64'(aw_log[0]), 64'h5100_0000);
    chk_data("t5b", 508);

    // 6: restart while a burst is in flight
    clear_logs();
    load(600, 16);
    start(32'h6000_0000, 16'd3);
    wait_beats("t6_reach2", 2);
    start(32'h2000_0000, 16'd1);
    wait_fd("t6_done", 1);
    tick(10);
    chk("t6_aw_n", 64'(aw_log.size()), 64'd2);
    chk("t6_aw0", 64'(aw_log[0]), 64'h6000_0000);
    chk("t6_aw1", 64'(aw_log[1]), 64'h2000_0000);
    chk("t6_beats", 64'(w_dat.size()), 64'd16);
    chk("t6_fd", 64'(fd_cnt), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("underflow", 64'(uf_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
